// File: rtl/rcc_switch_ctrl.sv
// rcc_switch_ctrl: sequences oscillator enable, ready qualification, rcc_cr update and settle, with fallback to 10M on oscillator loss
module rcc_switch_ctrl #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SETTLE_CYCLES  = 2048
) (
  input  logic       clk_10M,
  input  logic       rst_n,
  input  logic       sw_req,
  input  logic [1:0] sw_sel,
  input  logic       osc_rdy_32K,
  input  logic       osc_rdy_100M,
  output logic [1:0] rcc_cr,
  output logic       osc_en_32K,
  output logic       osc_en_100M,
  output logic [1:0] cur_sel,
  output logic       busy,
  output logic       sw_done,
  output logic       sw_err,
  output logic       osc_fail
);
  typedef enum logic [1:0] {IDLE, WAIT_RDY, SETTLE} state_t;
  localparam logic [15:0] STB_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] SET_LAST = 16'(SETTLE_CYCLES - 1);
  state_t      r_state, w_state;
  logic [1:0]  r_tgt, w_tgt, r_old, w_old, r_cr, w_cr, r_cur, w_cur;
  logic [15:0] r_stab, w_stab, r_to, w_to, r_set, w_set;
  logic        r_fb, w_fb, r_en32, w_en32, r_en100, w_en100;
  logic        r_done, w_done, r_err, w_err, r_fail, w_fail;
  logic [1:0]  r_s32, r_s100;
  logic        w_cur_rdy, w_tgt_rdy, w_loss;
  function automatic logic f_rdy(input logic [1:0] sel, input logic r32, input logic r100);
    return sel == 2'b00 ? 1'b1 : sel == 2'b01 ? r32 : sel == 2'b10 ? r100 : 1'b0;
  endfunction
  assign w_cur_rdy = f_rdy(r_cur, r_s32[1], r_s100[1]);
  assign w_tgt_rdy = f_rdy(r_tgt, r_s32[1], r_s100[1]);
  assign w_loss    = (r_cur != 2'b00) && !w_cur_rdy;
  always_comb begin
    w_state = r_state;
    w_tgt   = r_tgt;
    w_old   = r_old;
    w_cr    = r_cr;
    w_cur   = r_cur;
    w_stab  = r_stab;
    w_to    = r_to;
    w_set   = r_set;
    w_fb    = r_fb;
    w_en32  = r_en32;
    w_en100 = r_en100;
    w_done  = 1'b0;
    w_err   = 1'b0;
    w_fail  = 1'b0;
    if (r_state != SETTLE && w_loss) begin
      w_fail  = 1'b1;
      w_tgt   = 2'b00;
      w_old   = r_cur;
      w_cr    = 2'b00;
      w_set   = '0;
      w_fb    = 1'b1;
      w_state = SETTLE;
      if (r_state == WAIT_RDY && r_tgt == 2'b01) w_en32 = 1'b0;
      if (r_state == WAIT_RDY && r_tgt == 2'b10) w_en100 = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sw_req && sw_sel == 2'b11) w_err = 1'b1;
          else if (sw_req && sw_sel == r_cur) w_done = 1'b1;
          else if (sw_req) begin
            w_tgt   = sw_sel;
            w_old   = r_cur;
            w_en32  = r_en32 | (sw_sel == 2'b01);
            w_en100 = r_en100 | (sw_sel == 2'b10);
            w_stab  = '0;
            w_to    = '0;
            w_set   = '0;
            w_fb    = 1'b0;
            w_state = WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          w_to = r_to + 16'd1;
          if (w_tgt_rdy && r_to != 16'd0) begin
            if (r_stab == STB_LAST) begin
              w_cr    = r_tgt;
              w_set   = '0;
              w_state = SETTLE;
            end else w_stab = r_stab + 16'd1;
          end else w_stab = '0;
          if (w_state == WAIT_RDY && r_to == TO_LAST) begin
            w_en32  = r_tgt == 2'b01 ? 1'b0 : r_en32;
            w_en100 = r_tgt == 2'b10 ? 1'b0 : r_en100;
            w_err   = 1'b1;
            w_state = IDLE;
          end
        end
        SETTLE: begin
          w_set = r_set + 16'd1;
          if (r_set == SET_LAST) begin
            w_cur   = r_tgt;
            w_en32  = r_old == 2'b01 ? 1'b0 : r_en32;
            w_en100 = r_old == 2'b10 ? 1'b0 : r_en100;
            w_done  = !r_fb;
            w_state = IDLE;
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_10M) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tgt   <= '0;
      r_old   <= '0;
      r_cr    <= '0;
      r_cur   <= '0;
      r_stab  <= '0;
      r_to    <= '0;
      r_set   <= '0;
      r_fb    <= 1'b0;
      r_en32  <= 1'b0;
      r_en100 <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_fail  <= 1'b0;
      r_s32   <= '0;
      r_s100  <= '0;
    end else begin
      r_state <= w_state;
      r_tgt   <= w_tgt;
      r_old   <= w_old;
      r_cr    <= w_cr;
      r_cur   <= w_cur;
      r_stab  <= w_stab;
      r_to    <= w_to;
      r_set   <= w_set;
      r_fb    <= w_fb;
      r_en32  <= w_en32;
      r_en100 <= w_en100;
      r_done  <= w_done;
      r_err   <= w_err;
      r_fail  <= w_fail;
      r_s32   <= {r_s32[0], osc_rdy_32K};
      r_s100  <= {r_s100[0], osc_rdy_100M};
    end
  end
  assign rcc_cr      = r_cr;
  assign cur_sel     = r_cur;
  assign osc_en_32K  = r_en32;
  assign osc_en_100M = r_en100;
  assign busy        = r_state != IDLE;
  assign sw_done     = r_done;
  assign sw_err      = r_err;
  assign osc_fail    = r_fail;
endmodule

// File: tb/tb_rcc_switch_ctrl.sv
// tb_rcc_switch_ctrl: scoreboard bench for the clock-source switch sequencer
module tb_rcc_switch_ctrl;
  logic       clk_10M = 1'b0;
  logic       rst_n, sw_req, osc_rdy_32K, osc_rdy_100M;
  logic [1:0] sw_sel, rcc_cr, cur_sel;
  logic       osc_en_32K, osc_en_100M, busy, sw_done, sw_err, osc_fail;
  typedef struct {
    logic [2:0] k;
    int         c;
    logic [1:0] cr;
    logic [1:0] cur;
    logic       e32;
    logic       e100;
  } ev_t;
  ev_t        sb[$];
  ev_t        mon_e;
  logic [2:0] mon_p;
  int         cyc = 0;
  int         n_run = 0;
  int         n_fail = 0;
  int         e0, d;
  logic [6:0] gv;
  localparam logic [2:0] K_DONE = 3'b100, K_ERR = 3'b010, K_FAIL = 3'b001;
  rcc_switch_ctrl #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(64), .SETTLE_CYCLES(8)) u_dut (
    .clk_10M(clk_10M), .rst_n(rst_n), .sw_req(sw_req), .sw_sel(sw_sel),
    .osc_rdy_32K(osc_rdy_32K), .osc_rdy_100M(osc_rdy_100M), .rcc_cr(rcc_cr),
    .osc_en_32K(osc_en_32K), .osc_en_100M(osc_en_100M), .cur_sel(cur_sel),
    .busy(busy), .sw_done(sw_done), .sw_err(sw_err), .osc_fail(osc_fail)
  );
  always #50 clk_10M = ~clk_10M;
  always @(posedge clk_10M) cyc <= cyc + 1;
  assign mon_p = {sw_done, sw_err, osc_fail};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic push(input logic [2:0] k, input int c, input logic [1:0] cr, input logic [1:0] cur,
                      input logic e32, input logic e100);
    ev_t e;
    e.k = k; e.c = c; e.cr = cr; e.cur = cur; e.e32 = e32; e.e100 = e100;
    sb.push_back(e);
  endtask
  task automatic go(input logic [1:0] sel);
    sw_sel = sel;
    sw_req = 1'b1;
    @(negedge clk_10M);
    sw_req = 1'b0;
  endtask
  task automatic wait_to(input int k);
    while (cyc < e0 + k) @(negedge clk_10M);
  endtask
  always @(negedge clk_10M) begin
    if (mon_p != 3'b000) begin
      if (sb.size() == 0) chk("ev_unexpected", 32'(mon_p), 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk("ev_kind", 32'(mon_p), 32'(mon_e.k));
        chk("ev_cycle", cyc, mon_e.c);
        chk("ev_rcc_cr", 32'(rcc_cr), 32'(mon_e.cr));
        chk("ev_cur_sel", 32'(cur_sel), 32'(mon_e.cur));
        chk("ev_en32", 32'(osc_en_32K), 32'(mon_e.e32));
        chk("ev_en100", 32'(osc_en_100M), 32'(mon_e.e100));
      end
    end else if (sb.size() != 0 && cyc >= sb[0].c) begin
      mon_e = sb.pop_front();
      chk("ev_missing", 32'(mon_p), 32'(mon_e.k));
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0; sw_req = 1'b0; sw_sel = 2'b00; osc_rdy_32K = 1'b0; osc_rdy_100M = 1'b0;
    repeat (3) @(negedge clk_10M);
    chk("rst_rcc_cr", 32'(rcc_cr), 32'd0);
    chk("rst_cur_sel", 32'(cur_sel), 32'd0);
    chk("rst_en", 32'({osc_en_32K, osc_en_100M}), 32'd0);
    chk("rst_flags", 32'({busy, sw_done, sw_err, osc_fail}), 32'd0);
    rst_n = 1'b1;
    osc_rdy_100M = 1'b1;
    repeat (3) @(negedge clk_10M);
    e0 = cyc + 1;
    push(K_DONE, e0 + 13, 2'b10, 2'b10, 1'b0, 1'b1);
    go(2'b10);
    chk("t1_en100", 32'(osc_en_100M), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_to(4);
    chk("t1_cr_e4", 32'(rcc_cr), 32'd0);
    wait_to(5);
    chk("t1_cr_e5", 32'(rcc_cr), 32'd2);
    wait_to(12);
    chk("t1_cur_e12", 32'(cur_sel), 32'd0);
    wait_to(13);
    chk("t1_busy_e13", 32'(busy), 32'd0);
    repeat (2) @(negedge clk_10M);
    e0 = cyc + 1;
    push(K_DONE, e0 + 13, 2'b00, 2'b00, 1'b0, 1'b0);
    go(2'b00);
    wait_to(4);
    chk("t2_cr_e4", 32'(rcc_cr), 32'd2);
    wait_to(5);
    chk("t2_cr_e5", 32'(rcc_cr), 32'd0);
    wait_to(12);
    chk("t2_en100_e12", 32'(osc_en_100M), 32'd1);
    wait_to(13);
    chk("t2_en100_e13", 32'(osc_en_100M), 32'd0);
    repeat (2) @(negedge clk_10M);
    e0 = cyc + 1;
    push(K_ERR, e0 + 64, 2'b00, 2'b00, 1'b0, 1'b0);
    go(2'b01);
    chk("t3_en32", 32'(osc_en_32K), 32'd1);
    wait_to(63);
    chk("t3_busy_e63", 32'(busy), 32'd1);
    wait_to(64);
    chk("t3_busy_e64", 32'(busy), 32'd0);
    repeat (2) @(negedge clk_10M);
    gv = 7'b1111011;
    e0 = cyc + 1;
    push(K_DONE, e0 + 17, 2'b01, 2'b01, 1'b1, 1'b0);
    go(2'b01);
    for (int i = 0; i < 7; i++) begin
      osc_rdy_32K = gv[i];
      @(negedge clk_10M);
    end
    wait_to(8);
    chk("t4_cr_e8", 32'(rcc_cr), 32'd0);
    wait_to(9);
    chk("t4_cr_e9", 32'(rcc_cr), 32'd1);
    wait_to(19);
    e0 = cyc + 1;
    push(K_DONE, e0 + 13, 2'b10, 2'b10, 1'b0, 1'b1);
    go(2'b10);
    wait_to(15);
    d = cyc;
    osc_rdy_100M = 1'b0;
    push(K_FAIL, d + 3, 2'b00, 2'b10, 1'b0, 1'b1);
    repeat (2) @(negedge clk_10M);
    chk("t5_cr_d2", 32'(rcc_cr), 32'd2);
    repeat (8) @(negedge clk_10M);
    chk("t5_cur_d10", 32'(cur_sel), 32'd2);
    @(negedge clk_10M);
    chk("t5_cur_d11", 32'(cur_sel), 32'd0);
    chk("t5_en100_d11", 32'(osc_en_100M), 32'd0);
    chk("t5_busy_d11", 32'(busy), 32'd0);
    repeat (2) @(negedge clk_10M);
    e0 = cyc + 1;
    push(K_ERR, e0, 2'b00, 2'b00, 1'b0, 1'b0);
    go(2'b11);
    chk("t6_inv_busy", 32'(busy), 32'd0);
    @(negedge clk_10M);
    e0 = cyc + 1;
    push(K_DONE, e0, 2'b00, 2'b00, 1'b0, 1'b0);
    go(2'b00);
    chk("t6_same_busy", 32'(busy), 32'd0);
    @(negedge clk_10M);
    e0 = cyc + 1;
    push(K_DONE, e0 + 13, 2'b01, 2'b01, 1'b1, 1'b0);
    go(2'b01);
    wait_to(7);
    go(2'b10);
    chk("t6_ign_en100", 32'(osc_en_100M), 32'd0);
    chk("t6_ign_cr", 32'(rcc_cr), 32'd1);
    wait_to(14);
    chk("t6_cur", 32'(cur_sel), 32'd1);
    osc_rdy_100M = 1'b1;
    repeat (3) @(negedge clk_10M);
    e0 = cyc + 1;
    go(2'b10);
    wait_to(7);
    chk("t7_cr_pre", 32'(rcc_cr), 32'd2);
    chk("t7_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk_10M);
    chk("t7_rcc_cr", 32'(rcc_cr), 32'd0);
    chk("t7_cur_sel", 32'(cur_sel), 32'd0);
    chk("t7_en", 32'({osc_en_32K, osc_en_100M}), 32'd0);
    chk("t7_flags", 32'({busy, sw_done, sw_err, osc_fail}), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk_10M);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/rcc_switch_ctrl.md
# rcc_switch_ctrl

Clock-source switch sequencer that sits directly upstream of the glitch-free system clock switch and is the only driver of its `rcc_cr[1:0]` select. It accepts software switch requests and enables the target oscillator. It qualifies the oscillator's ready flag, updates `rcc_cr`, waits for the downstream handshake to settle, then powers down the old oscillator. It also falls back to 10 MHz when the active oscillator's ready flag drops.

## Interface
- `STABLE_CYCLES`, default 16: consecutive synchronized-ready cycles required before switching; range 1..65535.
- `TIMEOUT_CYCLES`, default 4096: maximum cycles spent waiting for a target oscillator ready; range 1..65535.
- `SETTLE_CYCLES`, default 2048: cycles held after an `rcc_cr` update so the downstream handshake completes on the slowest clock; range 1..65535.
- `clk_10M`  input  1  always-on 10 MHz clock; all logic is on its rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `sw_req`  input  1  one-cycle request pulse, sampled with `sw_sel`.
- `sw_sel`  input  2  requested source: 00 = 10M, 01 = 32K, 10 = 100M, 11 = invalid.
- `osc_rdy_32K`  input  1  asynchronous ready flag from the 32K oscillator.
- `osc_rdy_100M`  input  1  asynchronous ready flag from the 100M oscillator.
- `rcc_cr`  output  2  registered clock select to the switch; never 11.
- `osc_en_32K`  output  1  32K oscillator enable.
- `osc_en_100M`  output  1  100M oscillator enable.
- `cur_sel`  output  2  source currently committed.
- `busy`  output  1  high in any state other than IDLE.
- `sw_done`  output  1  one-cycle pulse when a requested switch completes.
- `sw_err`  output  1  one-cycle pulse on an invalid request or a ready timeout.
- `osc_fail`  output  1  one-cycle pulse when the active oscillator's ready flag is lost.

## Operation
- Ready flags pass through 2-flop synchronizers to give `rdy32_s` and `rdy100_s`. Ready for 10M is constant 1.
- Reset values:
  - `rcc_cr` = 00, `cur_sel` = 00.
  - `osc_en_32K` and `osc_en_100M` = 0.
  - `busy`, `sw_done`, `sw_err`, `osc_fail` = 0.
  - Synchronizer flops = 0, all counters = 0, state = IDLE.
- FSM states are IDLE, WAIT_RDY and SETTLE. Internal registers are `tgt[1:0]` and `old[1:0]`, plus 16-bit counters `stab_cnt`, `to_cnt` and `set_cnt`.
- **IDLE, when `sw_req` = 1:**
  - `sw_sel` = 11: pulse `sw_err`; stay in IDLE.
  - `sw_sel` = `cur_sel`: pulse `sw_done`; stay in IDLE; outputs unchanged.
  - Otherwise: set `tgt` = `sw_sel` and `old` = `cur_sel`. Set the target's `osc_en` (none for 00). Clear the counters. Go to WAIT_RDY.
- **WAIT_RDY:**
  - When the target's synchronized ready is 1: if `stab_cnt` == `STABLE_CYCLES`-1, load `rcc_cr` = `tgt` and go to SETTLE; otherwise increment `stab_cnt`.
  - When the target's synchronized ready is 0: clear `stab_cnt`.
  - `to_cnt` increments every cycle. If `to_cnt` reaches `TIMEOUT_CYCLES`-1 without switching:
    - Clear the target's `osc_en`.
    - Pulse `sw_err`.
    - Go to IDLE; `rcc_cr` and `cur_sel` are unchanged.
- **SETTLE:** `set_cnt` increments each cycle. When `set_cnt` == `SETTLE_CYCLES`-1:
  - Set `cur_sel` = `tgt`.
  - Clear `osc_en` of `old` if `old` != 00.
  - Pulse `sw_done`; this is suppressed for a fallback.
  - Go to IDLE.
- **Failure monitor (IDLE and WAIT_RDY):** if `cur_sel` != 00 and the synchronized ready of `cur_sel` is 0:
  - Pulse `osc_fail`.
  - Set `tgt` = 00 and `old` = `cur_sel`.
  - Load `rcc_cr` = 00.
  - In WAIT_RDY, also clear the pending target's `osc_en`.
  - Go to SETTLE, marked as a fallback.
- Failure has priority over request handling and timeout in the same cycle.
- SETTLE does not monitor failure; a failure is evaluated on the first IDLE cycle after SETTLE.
- `sw_req` outside IDLE is ignored, with no error.

## Timing
- Registered outputs update on the rising edge of `clk_10M`; no combinational input-to-output paths.
- Edge E0 samples `sw_req` → `busy` = 1 and target `osc_en` = 1 after E0.
- With the target's synchronized ready already stable high, `rcc_cr` updates on edge E0+`STABLE_CYCLES`+1.
- `sw_done`, the `cur_sel` update and the old `osc_en` deassert all occur `SETTLE_CYCLES` edges after the `rcc_cr` update; `busy` falls on that same edge.
- Ready-to-state latency is 2 cycles (synchronizer).
- Same-source or invalid requests: the `sw_done`/`sw_err` pulse is high for exactly the cycle after E0.
- Reset asserted mid-operation: all state returns to reset values on the next edge, regardless of FSM state.

## Test plan
- **Basic switch to 100M.** Parameters STABLE=4, TIMEOUT=64, SETTLE=8. Hold `osc_rdy_100M` = 1 and pulse `sw_req` with `sw_sel` = 10 at E0. Expect:
  - `osc_en_100M` = 1 after E0.
  - `rcc_cr` = 10 after E5.
  - `sw_done` = 1 and `cur_sel` = 10 after E13.
  - `busy` = 0 after E13.
- **Return to 10M.** From 100M, request 00. Expect:
  - `rcc_cr` = 00 after E5.
  - After E13: `osc_en_100M` = 0, `cur_sel` = 00, `sw_done` pulse.
- **Timeout.** Request 01 with `osc_rdy_32K` = 0 held. Expect:
  - `sw_err` after E64.
  - `osc_en_32K` = 0; `rcc_cr` = 00 unchanged.
- **Glitchy ready.** Toggle `osc_rdy_32K` 1,1,0,1,1,1,1. Expect the `rcc_cr` update only after 4 consecutive synchronized-high cycles.
- **Oscillator loss.** In IDLE at 100M, drop `osc_rdy_100M`. Expect:
  - `osc_fail` pulse 3 edges later, with `rcc_cr` = 00 on that same edge.
  - After 8 more edges: `cur_sel` = 00, `osc_en_100M` = 0, no `sw_done`.
- **Invalid and redundant requests.**
  - `sw_sel` = 11 → `sw_err` pulse.
  - `sw_sel` = `cur_sel` → `sw_done` pulse.
  - `sw_req` during SETTLE → ignored.
  - `rst_n` = 0 mid-SETTLE → all outputs at reset values after the next edge.
